// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipelined datapath: decoded control layout
// and immediate sign extension.
package pipe_pkg;

  localparam int         CTRL_W   = 9;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         IMM_W    = 16;
  localparam int         SEXT_W   = 32;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  function automatic logic [SEXT_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
    return {{(SEXT_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance events; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, IF/ID stall generation,
// EX flush / downstream hold handling, and saturating stall/flush event counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [15:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              stall_d,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t id_ctrl_s;
  ctrl_t ex_ctrl_q;
  logic  load_use;

  assign id_ctrl_s    = ctrl_t'(id_ctrl);
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_write_reg = ex_ctrl_q.reg_dst ? ex_rd : ex_rt;

  // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
  assign load_use = ex_valid && ex_ctrl_q.mem_to_reg
                 && (ex_write_reg != REG_AW'(REG_ZERO))
                 && id_valid
                 && ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));

  assign stall_d = !ex_flush && (ex_hold || load_use);

  // NOTE: data fields are reset as well so every ex_* output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl_q <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
    end else if (ex_flush) begin
      ex_valid  <= 1'b0;
      ex_ctrl_q <= '0;
    end else if (!ex_hold) begin
      if (load_use) begin
        ex_valid  <= 1'b0;
        ex_ctrl_q <= '0;
      end else begin
        ex_valid  <= id_valid;
        ex_ctrl_q <= id_valid ? id_ctrl_s : '0;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_rd     <= id_rd;
        ex_rd1    <= id_rd1;
        ex_rd2    <= id_rd2;
        ex_imm    <= DATA_W'(sign_ext(id_imm));
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load_use && !ex_flush && !ex_hold),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ex_flush && ex_valid),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;

  localparam logic [8:0] CTRL_LW  = 9'b1_1_0_1_0_0_010;
  localparam logic [8:0] CTRL_ADD = 9'b1_0_0_0_1_0_010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rd1, id_rd2;
  logic [15:0] id_imm;
  logic [8:0]  id_ctrl;
  logic        ex_flush, ex_hold;

  logic        stall_d, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_write_reg;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [8:0]  ex_ctrl;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall_d, s_ex_valid;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd, s_ex_write_reg;
  logic [31:0] s_ex_rd1, s_ex_rd2, s_ex_imm;
  logic [8:0]  s_ex_ctrl;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .stall_d(stall_d), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_write_reg(ex_write_reg),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .stall_d(s_stall_d), .ex_valid(s_ex_valid),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_write_reg(s_ex_write_reg),
    .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1,
                         input logic [15:0] imm, input logic [8:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = d1; id_rd2 = ~d1; id_imm = imm; id_ctrl = ctrl;
    #1;
  endtask

  initial begin
    // Reset with random data inputs and the clock running
    rst_n    = 1'b0;
    ex_flush = 1'b0;
    ex_hold  = 1'b0;
    id_valid = 1'b1;
    id_rs    = 5'($urandom);
    id_rt    = 5'($urandom);
    id_rd    = 5'($urandom);
    id_rd1   = $urandom;
    id_rd2   = $urandom;
    id_imm   = 16'($urandom);
    id_ctrl  = CTRL_LW;
    #2;
    check("rst_valid_async", 32'(ex_valid), 32'd0);
    step(); step();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_rd1", ex_rd1, 32'd0);
    check("rst_rd2", ex_rd2, 32'd0);
    check("rst_imm", ex_imm, 32'd0);
    check("rst_rs", 32'(ex_rs), 32'd0);
    check("rst_wreg", 32'(ex_write_reg), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_stall_d", 32'(stall_d), 32'd0);

    // Release reset between edges, then first capture
    #2;
    rst_n = 1'b1;
    present(1'b1, 5'd1, 5'd2, 5'd3, 32'hA5A5_0001, 16'h8000, CTRL_ADD);
    step();
    check("cap_valid", 32'(ex_valid), 32'd1);
    check("cap_rd1", ex_rd1, 32'hA5A5_0001);
    check("cap_rd2", ex_rd2, 32'h5A5A_FFFE);
    check("cap_imm", ex_imm, 32'hFFFF_8000);
    check("cap_ctrl", 32'(ex_ctrl), 32'(CTRL_ADD));
    check("cap_wreg_rd", 32'(ex_write_reg), 32'd3);

    // Load-use: lw $5 then add reading $5
    present(1'b1, 5'd1, 5'd5, 5'd0, 32'h0000_0100, 16'h0004, CTRL_LW);
    step();
    check("lw_wreg_rt", 32'(ex_write_reg), 32'd5);
    check("lw_imm_pos", ex_imm, 32'h0000_0004);
    present(1'b1, 5'd5, 5'd6, 5'd7, 32'h0000_0011, 16'h0000, CTRL_ADD);
    check("lu_stall_d", 32'(stall_d), 32'd1);
    step();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    check("lu_stall_drop", 32'(stall_d), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    step();
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_rd1", ex_rd1, 32'h0000_0011);
    check("lu_add_wreg", 32'(ex_write_reg), 32'd7);

    // No false hazard: lw $0 then reader of $0
    present(1'b1, 5'd3, 5'd0, 5'd0, 32'h0000_0200, 16'h0008, CTRL_LW);
    step();
    present(1'b1, 5'd0, 5'd0, 5'd8, 32'h0000_0022, 16'h0000, CTRL_ADD);
    check("zero_no_stall", 32'(stall_d), 32'd0);
    step();
    check("zero_no_bubble", 32'(ex_valid), 32'd1);
    check("zero_ctrl", 32'(ex_ctrl), 32'(CTRL_ADD));

    // No false hazard: lw $5 then reader of $6/$7
    present(1'b1, 5'd1, 5'd5, 5'd0, 32'h0000_0300, 16'h000C, CTRL_LW);
    step();
    present(1'b1, 5'd6, 5'd7, 5'd9, 32'h0000_0033, 16'h0000, CTRL_ADD);
    check("other_no_stall", 32'(stall_d), 32'd0);
    step();
    check("other_no_bubble", 32'(ex_valid), 32'd1);
    check("other_rs", 32'(ex_rs), 32'd6);
    check("other_stall_cnt", 32'(stall_cnt), 32'd1);

    // Flush of a live instruction
    present(1'b1, 5'd2, 5'd3, 5'd4, 32'h0000_0044, 16'h0000, CTRL_ADD);
    ex_flush = 1'b1;
    #1;
    check("flush_stall_d", 32'(stall_d), 32'd0);
    step();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_ctrl", 32'(ex_ctrl), 32'd0);
    check("flush_cnt1", 32'(flush_cnt), 32'd1);
    ex_flush = 1'b0;
    step();
    check("post_flush_valid", 32'(ex_valid), 32'd1);

    // Flush together with hold: flush wins
    ex_flush = 1'b1;
    ex_hold  = 1'b1;
    #1;
    check("flush_hold_stall_d", 32'(stall_d), 32'd0);
    step();
    check("flush_hold_valid", 32'(ex_valid), 32'd0);
    check("flush_hold_ctrl", 32'(ex_ctrl), 32'd0);
    check("flush_cnt2", 32'(flush_cnt), 32'd2);
    ex_flush = 1'b0;
    ex_hold  = 1'b0;

    // Hold for 3 cycles while ID changes, then capture on release
    present(1'b1, 5'd9, 5'd10, 5'd11, 32'hDEAD_BEEF, 16'h0001, CTRL_ADD);
    step();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 5'(12 + i), 5'd13, 5'd1, 32'hCAFE_0000 + 32'(i), 16'hFFFF, CTRL_LW);
      check("hold_stall_d", 32'(stall_d), 32'd1);
      step();
      check("hold_rd1", ex_rd1, 32'hDEAD_BEEF);
      check("hold_rs", 32'(ex_rs), 32'd9);
      check("hold_ctrl", 32'(ex_ctrl), 32'(CTRL_ADD));
    end
    ex_hold = 1'b0;
    present(1'b1, 5'd14, 5'd15, 5'd16, 32'hCAFE_0003, 16'h7FFF, CTRL_ADD);
    step();
    check("release_rd1", ex_rd1, 32'hCAFE_0003);
    check("release_rs", 32'(ex_rs), 32'd14);
    check("release_imm", ex_imm, 32'h0000_7FFF);
    check("hold_stall_cnt", 32'(stall_cnt), 32'd1);

    // Five more load-use events
    for (int i = 0; i < 5; i++) begin
      present(1'b1, 5'd1, 5'd5, 5'd0, 32'h0000_0400, 16'h0010, CTRL_LW);
      step();
      present(1'b1, 5'd2, 5'd5, 5'd6, 32'h0000_0055, 16'h0000, CTRL_ADD);
      step();
      step();
    end
    check("sat_wide_stall_cnt", 32'(stall_cnt), 32'd6);
    check("sat_narrow_stall_cnt", 32'(s_stall_cnt), 32'd3);
    check("sat_narrow_flush_cnt", 32'(s_flush_cnt), 32'd2);

    // Reset asserted mid-stall clears state without a clock edge
    present(1'b1, 5'd1, 5'd5, 5'd0, 32'h0000_0500, 16'h0014, CTRL_LW);
    step();
    present(1'b1, 5'd5, 5'd5, 5'd6, 32'h0000_0066, 16'h0000, CTRL_ADD);
    check("mid_stall_d", 32'(stall_d), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("mid_rst_stall_d", 32'(stall_d), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register with load-use hazard detection for the 5-stage pipelined processor. It captures the RegisterFile read data (RD1/RD2), the sign-extended immediate, register addresses and decoded control at each rising edge. It inserts bubbles on load-use hazards, drives the IF/ID stall, and honours EX-stage flush and downstream hold. Saturating stall and flush counters support performance debug.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs, id_rt, id_rd  in  REG_AW each  decoded register fields
- id_rd1, id_rd2  in  DATA_W each  RegisterFile RD1/RD2
- id_imm  in  16  raw immediate
- id_ctrl  in  9  packed control {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, alu_ctrl[2:0]}
- ex_flush  in  1  branch redirect from EX; squash ID/EX contents
- ex_hold  in  1  downstream not accepting; freeze ID/EX
- stall_d  out  1  freeze PC and IF/ID this cycle (combinational)
- ex_valid  out  1  ID/EX holds a live instruction
- ex_rs, ex_rt, ex_rd  out  REG_AW each  registered fields
- ex_write_reg  out  REG_AW  destination register: ex_rd if reg_dst, else ex_rt
- ex_rd1, ex_rd2  out  DATA_W each  registered operands
- ex_imm  out  DATA_W  sign-extended id_imm
- ex_ctrl  out  9  registered control, forced to 0 when ex_valid=0
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- load_use = ex_valid & ex_ctrl.mem_to_reg & (ex_write_reg != 0) & id_valid & (ex_write_reg == id_rs | ex_write_reg == id_rt).
- stall_d = ~ex_flush & (ex_hold | load_use).
- Next-state priority at each rising edge, highest first:
  - ex_flush: ex_valid←0, ex_ctrl←0. Data fields are don't-care and are held.
  - ex_hold: every register holds.
  - load_use: bubble. ex_valid←0, ex_ctrl←0.
  - Otherwise: load all fields from id_*, with ex_valid←id_valid. When id_valid=0, ex_ctrl←0.
- ex_imm = {{16{id_imm[15]}}, id_imm}, registered.
- stall_cnt increments on each cycle with load_use & ~ex_flush & ~ex_hold. flush_cnt increments on each cycle with ex_flush & ex_valid. Both saturate at 2^CNT_W−1.
- No write-back bypass. RegisterFile writes on the falling edge, so id_rd1/id_rd2 already reflect the WB value at the rising edge.

## Timing
- Reset (async, rst_n=0): ex_valid=0, all ex_* fields=0, stall_cnt=flush_cnt=0. stall_d then evaluates to 0.
- Reset deasserts synchronously to the next rising edge. The first capture happens on the first rising edge with rst_n=1.
- Latency is 1 cycle from id_* to ex_*.
- A load-use hazard costs exactly one bubble. In the following cycle the load has left ID/EX, load_use drops, and the held instruction advances.
- A load followed by a consumer of $0 produces no stall.
- ex_flush in the same cycle as ex_hold: flush wins and ex_valid clears.
- Reset asserted mid-stall: all state clears immediately, independent of clk.

## Structure
- Package pipe_pkg holds the ctrl_t packed struct (9-bit field order above), the localparams CTRL_W=9 and REG_ZERO=5'd0, and the sign-extension function.
- One sub-module, sat_counter (CNT_W, inc, saturate), instantiated twice.
- Everything else is flat in id_ex_stage.

## Test plan
- Reset: hold rst_n=0 with random inputs → every ex_* output, counter and stall_d is 0. Release, then present id_valid=1, rs=1, rt=2, rd1=32'hA5A5_0001, imm=16'h8000 → next cycle ex_rd1=32'hA5A5_0001 and ex_imm=32'hFFFF_8000.
- Load-use: lw $5 in ID/EX (mem_to_reg=1, reg_dst=0, rt=5) with an add that reads rs=5 in ID → stall_d=1 for 1 cycle, ex_valid=0 for 1 cycle, then the add appears. stall_cnt=1.
- No false hazard: lw $0 followed by a reader of $0, and lw $5 followed by a reader of rs=6/rt=7 → stall_d=0 and no bubble.
- Flush: ex_flush=1 with ex_valid=1 → next cycle ex_valid=0 and ex_ctrl=0. flush_cnt=1. Repeat with ex_hold=1 asserted at the same time → same result.
- Hold: ex_hold=1 for 3 cycles while id_* changes → ex_* is frozen and stall_d=1 throughout. On release, the ID value present at release is captured.
- Saturation: CNT_W=2, force 5 load-use events → stall_cnt stays at 3.
